// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz defaults) and the coordinate type.
package vga_timing_pkg;

    localparam int unsigned COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int unsigned H_DISPLAY = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned V_DISPLAY = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;

    localparam int unsigned H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int unsigned V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter with terminal count, registered sync decode and
// a next-cycle visible flag so the parent can register display_on in step.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL      = H_TOTAL,
    parameter int unsigned DISP       = H_DISPLAY,
    parameter int unsigned SYNC_START = H_SYNC_START,
    parameter int unsigned SYNC_END   = H_SYNC_END,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en_i,
    output coord_t count_o,
    output logic   sync_o,
    output logic   tc_c_o,
    output logic   vis_nxt_c_o
);

    localparam coord_t LAST    = coord_t'(TOTAL - 1);
    localparam coord_t DISP_LM = coord_t'(DISP);
    localparam coord_t SYNC_LO = coord_t'(SYNC_START);
    localparam coord_t SYNC_HI = coord_t'(SYNC_END);

    coord_t count_q, count_d;
    logic   sync_q, sync_d;
    logic   tc;

    // Next count and decodes of that next count, so outputs line up with it.
    always_comb begin
        tc      = en_i && (count_q == LAST);
        count_d = count_q;
        if (en_i) begin
            count_d = tc ? '0 : count_q + coord_t'(1);
        end
        sync_d      = ((count_d >= SYNC_LO) && (count_d <= SYNC_HI)) ^ ACTIVE_LOW;
        vis_nxt_c_o = (count_d < DISP_LM);
    end

    // Counter and sync registers; sync comes out of reset deasserted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            sync_q  <= ACTIVE_LOW;
        end else begin
            count_q <= count_d;
            sync_q  <= sync_d;
        end
    end

    assign count_o = count_q;
    assign sync_o  = sync_q;
    assign tc_c_o  = tc;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, sync pulses, visible flag.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_DISPLAY       = vga_timing_pkg::H_DISPLAY,
    parameter int unsigned H_FRONT         = vga_timing_pkg::H_FRONT,
    parameter int unsigned H_SYNC          = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BACK          = vga_timing_pkg::H_BACK,
    parameter int unsigned V_DISPLAY       = vga_timing_pkg::V_DISPLAY,
    parameter int unsigned V_FRONT         = vga_timing_pkg::V_FRONT,
    parameter int unsigned V_SYNC          = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BACK          = vga_timing_pkg::V_BACK,
    parameter int unsigned SYNC_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos
);

    localparam int unsigned HT  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned VT  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HSS = H_DISPLAY + H_FRONT;
    localparam int unsigned VSS = V_DISPLAY + V_FRONT;
    localparam bit          SYNC_LOW = (SYNC_ACTIVE_LOW != 0);

    coord_t h_count, v_count;
    logic   h_tc, v_tc_unused;
    logic   h_vis_nxt, v_vis_nxt;
    logic   display_on_q;

    // Horizontal axis free-runs every pixel clock.
    vga_axis_counter #(
        .TOTAL(HT), .DISP(H_DISPLAY), .SYNC_START(HSS), .SYNC_END(HSS + H_SYNC - 1),
        .ACTIVE_LOW(SYNC_LOW)
    ) u_h (
        .clk(clk), .rst_n(rst_n), .en_i(1'b1),
        .count_o(h_count), .sync_o(hsync), .tc_c_o(h_tc), .vis_nxt_c_o(h_vis_nxt)
    );

    // Vertical axis advances on the horizontal wrap.
    vga_axis_counter #(
        .TOTAL(VT), .DISP(V_DISPLAY), .SYNC_START(VSS), .SYNC_END(VSS + V_SYNC - 1),
        .ACTIVE_LOW(SYNC_LOW)
    ) u_v (
        .clk(clk), .rst_n(rst_n), .en_i(h_tc),
        .count_o(v_count), .sync_o(vsync), .tc_c_o(v_tc_unused), .vis_nxt_c_o(v_vis_nxt)
    );

    // Visible flag registered from both next-state decodes; (0,0) is visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            display_on_q <= 1'b1;
        end else begin
            display_on_q <= h_vis_nxt && v_vis_nxt;
        end
    end

    assign display_on = display_on_q;
    assign hpos       = h_count;
    assign vpos       = v_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance for line timing and a
// reduced-mode active-high instance (15x11 raster) for whole-frame behaviour.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a_n, rst_b_n;
    logic       hs_a, vs_a, de_a, hs_b, vs_b, de_b;
    logic [9:0] hp_a, vp_a, hp_b, vp_b;

    vga_timing_gen dut_a (
        .clk(clk), .rst_n(rst_a_n), .hsync(hs_a), .vsync(vs_a),
        .display_on(de_a), .hpos(hp_a), .vpos(vp_a)
    );

    // Small mode: H 8+2+3+2=15, hsync 10..12; V 6+2+2+1=11, vsync 8..9; frame 165.
    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(1),
        .SYNC_ACTIVE_LOW(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_b_n), .hsync(hs_b), .vsync(vs_b),
        .display_on(de_b), .hpos(hp_b), .vpos(vp_b)
    );

    typedef struct {
        bit         sel_b;
        int         t;
        logic [9:0] hp;
        logic [9:0] vp;
        logic       hs;
        logic       vs;
        logic       de;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input bit sel_b, input int t, input int hp, input int vp,
                                input bit hs, input bit vs, input bit de);
        vec_t v;
        v.sel_b = sel_b; v.t = t; v.hp = 10'(hp); v.vp = 10'(vp);
        v.hs = hs; v.vs = vs; v.de = de;
        return v;
    endfunction

    function automatic logic [22:0] pack(input logic [9:0] hp, input logic [9:0] vp,
                                         input logic hs, input logic vs, input logic de);
        return {hp, vp, hs, vs, de};
    endfunction

    initial begin
        int align_a = 0, align_b = 0, model_a = 0, model_b = 0;
        int last_origin = -1, origins = 0, period_bad = 0;
        int hs_pulses_b = 0, hs_width_bad = 0, hs_run = 0;
        int hs_low_a = 0, de_low_a = 0;
        logic prev_hs_b = 1'b0;
        bit found;

        // Default mode (active-low syncs).
        vecs.push_back(mk(0,    1,   1, 0, 1, 1, 1));
        vecs.push_back(mk(0,  639, 639, 0, 1, 1, 1));
        vecs.push_back(mk(0,  640, 640, 0, 1, 1, 0));
        vecs.push_back(mk(0,  655, 655, 0, 1, 1, 0));
        vecs.push_back(mk(0,  656, 656, 0, 0, 1, 0));
        vecs.push_back(mk(0,  751, 751, 0, 0, 1, 0));
        vecs.push_back(mk(0,  752, 752, 0, 1, 1, 0));
        vecs.push_back(mk(0,  799, 799, 0, 1, 1, 0));
        vecs.push_back(mk(0,  800,   0, 1, 1, 1, 1));
        vecs.push_back(mk(0, 1456, 656, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1600,   0, 2, 1, 1, 1));
        // Small mode (active-high syncs).
        vecs.push_back(mk(1,    7,  7,  0, 0, 0, 1));
        vecs.push_back(mk(1,    8,  8,  0, 0, 0, 0));
        vecs.push_back(mk(1,   10, 10,  0, 1, 0, 0));
        vecs.push_back(mk(1,   13, 13,  0, 0, 0, 0));
        vecs.push_back(mk(1,   15,  0,  1, 0, 0, 1));
        vecs.push_back(mk(1,   90,  0,  6, 0, 0, 0));
        vecs.push_back(mk(1,  119, 14,  7, 0, 0, 0));
        vecs.push_back(mk(1,  120,  0,  8, 0, 1, 0));
        vecs.push_back(mk(1,  130, 10,  8, 1, 1, 0));
        vecs.push_back(mk(1,  149, 14,  9, 0, 1, 0));
        vecs.push_back(mk(1,  150,  0, 10, 0, 0, 0));
        vecs.push_back(mk(1,  164, 14, 10, 0, 0, 0));
        vecs.push_back(mk(1,  165,  0,  0, 0, 0, 1));

        // Reset held for 3 clocks.
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        repeat (3) tick();
        check("reset_a", pack(hp_a, vp_a, hs_a, vs_a, de_a), pack(10'd0, 10'd0, 1'b1, 1'b1, 1'b1));
        check("reset_b", pack(hp_b, vp_b, hs_b, vs_b, de_b), pack(10'd0, 10'd0, 1'b0, 1'b0, 1'b1));
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;

        // Free run; t counts edges since reset release.
        for (int t = 0; t < 2000; t++) begin
            int ha, va, hb, vb;
            foreach (vecs[i]) begin
                if (vecs[i].t == t) begin
                    if (vecs[i].sel_b)
                        check($sformatf("vec%0d_b_t%0d", i, t), pack(hp_b, vp_b, hs_b, vs_b, de_b),
                              pack(vecs[i].hp, vecs[i].vp, vecs[i].hs, vecs[i].vs, vecs[i].de));
                    else
                        check($sformatf("vec%0d_a_t%0d", i, t), pack(hp_a, vp_a, hs_a, vs_a, de_a),
                              pack(vecs[i].hp, vecs[i].vp, vecs[i].hs, vecs[i].vs, vecs[i].de));
                end
            end

            // Independent model from elapsed cycles.
            ha = t % 800;
            va = (t / 800) % 525;
            hb = t % 15;
            vb = (t / 15) % 11;
            if (pack(hp_a, vp_a, hs_a, vs_a, de_a) !=
                pack(10'(ha), 10'(va), !(ha >= 656 && ha <= 751), !(va >= 490 && va <= 491),
                     (ha < 640) && (va < 480)))
                model_a++;
            if (pack(hp_b, vp_b, hs_b, vs_b, de_b) !=
                pack(10'(hb), 10'(vb), (hb >= 10 && hb <= 12), (vb >= 8 && vb <= 9),
                     (hb < 8) && (vb < 6)))
                model_b++;

            // Same-cycle decode of the presented coordinates.
            if (hs_a != !(hp_a >= 656 && hp_a <= 751) || vs_a != !(vp_a >= 490 && vp_a <= 491) ||
                de_a != ((hp_a < 640) && (vp_a < 480)))
                align_a++;
            if (hs_b != (hp_b >= 10 && hp_b <= 12) || vs_b != (vp_b >= 8 && vp_b <= 9) ||
                de_b != ((hp_b < 8) && (vp_b < 6)))
                align_b++;

            // Frame period of small mode.
            if (hp_b == 10'd0 && vp_b == 10'd0) begin
                if (last_origin >= 0 && (t - last_origin) != 165) period_bad++;
                last_origin = t;
                origins++;
            end

            // hsync pulse count and widths in small mode.
            if (hs_b) begin
                if (!prev_hs_b && t < 165) hs_pulses_b++;
                hs_run++;
            end else begin
                if (prev_hs_b && hs_run != 3) hs_width_bad++;
                hs_run = 0;
            end
            prev_hs_b = hs_b;

            if (t < 800) begin
                if (!hs_a) hs_low_a++;
                if (!de_a) de_low_a++;
            end
            tick();
        end

        check("model_a_mism", model_a, 0);
        check("model_b_mism", model_b, 0);
        check("align_a_mism", align_a, 0);
        check("align_b_mism", align_b, 0);
        check("frame_period_b", period_bad, 0);
        check("frame_origins_b", origins, 13);
        check("hsync_pulses_frame_b", hs_pulses_b, 11);
        check("hsync_width_b", hs_width_bad, 0);
        check("hsync_low_line_a", hs_low_a, 96);
        check("de_low_line_a", de_low_a, 160);

        // Mid-line reset on the default instance at hpos=300.
        found = 1'b0;
        for (int n = 0; n < 1000 && !found; n++) begin
            if (hp_a == 10'd300) found = 1'b1;
            else tick();
        end
        check("wait_a_300", found, 1);
        rst_a_n = 1'b0;
        tick();
        rst_a_n = 1'b1;
        check("midreset_a", pack(hp_a, vp_a, hs_a, vs_a, de_a), pack(10'd0, 10'd0, 1'b1, 1'b1, 1'b1));
        tick();
        check("midreset_a_t1", pack(hp_a, vp_a, hs_a, vs_a, de_a), pack(10'd1, 10'd0, 1'b1, 1'b1, 1'b1));
        repeat (800) tick();
        check("midreset_a_t801", pack(hp_a, vp_a, hs_a, vs_a, de_a), pack(10'd1, 10'd1, 1'b1, 1'b1, 1'b1));

        // Mid-frame reset on the small instance at (5,3).
        found = 1'b0;
        for (int n = 0; n < 400 && !found; n++) begin
            if (hp_b == 10'd5 && vp_b == 10'd3) found = 1'b1;
            else tick();
        end
        check("wait_b_5_3", found, 1);
        rst_b_n = 1'b0;
        tick();
        rst_b_n = 1'b1;
        check("midreset_b", pack(hp_b, vp_b, hs_b, vs_b, de_b), pack(10'd0, 10'd0, 1'b0, 1'b0, 1'b1));
        tick();
        check("midreset_b_t1", pack(hp_b, vp_b, hs_b, vs_b, de_b), pack(10'd1, 10'd0, 1'b0, 1'b0, 1'b1));
        repeat (15) tick();
        check("midreset_b_t16", pack(hp_b, vp_b, hs_b, vs_b, de_b), pack(10'd1, 10'd1, 1'b0, 1'b0, 1'b1));
        repeat (149) tick();
        check("midreset_b_t165", pack(hp_b, vp_b, hs_b, vs_b, de_b), pack(10'd0, 10'd0, 1'b0, 1'b0, 1'b1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA raster timing: horizontal and vertical pixel counters, hsync/vsync pulses and a visible-area flag.
- Default mode is 640x480 @ 60 Hz with a 25.175/25 MHz pixel clock, one pixel per clk.
- Sits at the root of the video pipeline. Pixel generators consume hpos/vpos/display_on. The top level routes hsync/vsync straight to pins.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE_LOW, 1, 1 = sync pulses drive 0 when asserted (VGA 640x480 standard); 0 = active-high

Ports:
- clk  in  1  pixel clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- hsync  out  1  horizontal sync, polarity per SYNC_ACTIVE_LOW
- vsync  out  1  vertical sync, polarity per SYNC_ACTIVE_LOW
- display_on  out  1  high while (hpos,vpos) lies in the visible area
- hpos  out  10  current pixel column, 0..H_TOTAL-1
- vpos  out  10  current line, 0..V_TOTAL-1

Behaviour:
- Derived constants:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK = 800.
  - V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK = 525.
- Sync windows:
  - H sync window: H_DISPLAY+H_FRONT .. H_DISPLAY+H_FRONT+H_SYNC-1 = 656..751 inclusive.
  - V sync window: V_DISPLAY+V_FRONT .. V_DISPLAY+V_FRONT+V_SYNC-1 = 490..491 inclusive.
- Reset: when rst_n=0 at a clk edge, the following take effect next cycle:
  - hpos=0, vpos=0
  - hsync and vsync deasserted (1 when active-low)
  - display_on=1, since (0,0) is visible
  - Reset mid-frame restarts the raster at (0,0) immediately.
- hpos: increments by 1 every clk. At H_TOTAL-1 (799) it wraps to 0.
- vpos:
  - Increments by 1 on the cycle hpos wraps.
  - When vpos=V_TOTAL-1 (524) and hpos wraps, vpos wraps to 0.
  - Otherwise holds.
- One frame = H_TOTAL*V_TOTAL = 420000 clks. (0,0) recurs exactly every 420000 cycles.
- hsync, vsync and display_on are registered outputs, decoded from the next-state counter values, so they align with the hpos/vpos presented in the same cycle. There is no pipeline skew and no glitches.
- hsync is asserted iff hpos is in 656..751. vsync is asserted iff vpos is in 490..491. vsync spans whole lines, changing when hpos wraps to 0.
- display_on = (hpos < H_DISPLAY) && (vpos < V_DISPLAY). It is low at hpos=640..799 and at vpos=480..524.
- Counters never exceed H_TOTAL-1 / V_TOTAL-1. Widths are 10 bits, which is sufficient for totals up to 1024. Parameter totals above 1024 are unsupported.
- There are no enable or input dependencies. The block free-runs after reset.

Decomposition:
- Shared package vga_timing_pkg holds:
  - default timing constants and the derived H_TOTAL, V_TOTAL, H_SYNC_START/END, V_SYNC_START/END
  - a 10-bit coordinate typedef (coord_t)
- One natural sub-module: vga_axis_counter. It is a parameterised wrap counter with a terminal-count output and a sync/visible window decode. It is instantiated twice; the vertical instance is enabled by the horizontal terminal count.

Test Plan:
- Reset: hold rst_n=0 for 3 clks, release.
  - During/after reset: hpos=0, vpos=0, hsync=1, vsync=1, display_on=1.
  - Next clk: hpos=1.
- Line timing: run from reset.
  - hsync goes 0 when hpos=656 and returns to 1 at hpos=752.
  - display_on goes 0 at hpos=640 and returns to 1 at hpos=0.
  - hpos 799 -> 0 with vpos 0 -> 1 on the same edge.
- Frame timing:
  - vsync goes 0 at (hpos=0, vpos=490) and returns to 1 at (0, 492).
  - display_on stays 0 for all of vpos 480..524.
  - (799, 524) -> (0, 0).
- Period check: count clks between successive (0,0) -> 420000. Count hsync pulses per frame -> 525, each 96 clks wide.
- Mid-frame reset: assert rst_n=0 at (hpos=300, vpos=200) for 1 clk -> next cycle (0,0), display_on=1, syncs deasserted; counting resumes normally.
- Alignment: every cycle, check display_on/hsync/vsync against a combinational decode of the same-cycle hpos/vpos -> zero mismatches over 2 full frames.
